// File: rtl/ts_checker.sv
// Transport-stream integrity checker: sync, 188-byte length, per-PID continuity, lock and counters.
// Define TS_CHECKER_CC_EN to build the per-channel continuity-counter check; otherwise CC_ERR is tied 0.
module ts_checker #(
  parameter int          PKT_LEN  = 188,
  parameter logic [12:0] PID_BASE = 13'h1000,
  parameter int          LOCK_CNT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA,
  input  logic        D_VALID,
  input  logic        P_SYNC,
  output logic        LOCKED,
  output logic        SYNC_ERR,
  output logic        LEN_ERR,
  output logic        CC_ERR,
  output logic [12:0] PID_OUT,
  output logic        PID_STB,
  output logic [31:0] PKT_CNT,
  output logic [15:0] ERR_CNT
);

  // state | meaning
  // HUNT  | no packet alignment, waiting for P_SYNC with 8'h47
  // PKT   | inside a packet, bc_q is the index of the next byte
  typedef enum logic {HUNT = 1'b0, PKT = 1'b1} state_t;

  localparam int BCW = $clog2(PKT_LEN);
  localparam int GW  = $clog2(LOCK_CNT + 1);
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  state_t          state_q, state_d;
  logic [BCW-1:0]  bc_q, bc_d;
  logic [4:0]      pid_hi_q, pid_hi_d;
  logic [12:0]     pid_out_q, pid_out_d;
  logic            pid_stb_q, pid_stb_d;
  logic            sync_err_q, sync_err_d;
  logic            len_err_q, len_err_d;
  logic            cc_err_q, cc_err_d;
  logic            pkt_err_q, pkt_err_d;
  logic [GW-1:0]   good_q, good_d;
  logic            locked_q, locked_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            is_sync;
  logic            cc_mis, afc_rsv;
  logic [1:0]      err_inc;
  logic [16:0]     err_sum;

  assign is_sync = (DATA == SYNC_BYTE);

`ifdef TS_CHECKER_CC_EN
  logic [3:0][3:0] last_cc_q, last_cc_d;
  logic [3:0]      seen_q, seen_d;
  logic            hdr3;
  logic [12:0]     pid_off;
  logic            ch_hit;
  logic [1:0]      ch;
  logic [3:0]      cc_exp;

  assign hdr3    = D_VALID && (state_q == PKT) && !P_SYNC && (bc_q == BCW'(3));
  assign pid_off = pid_out_q - PID_BASE;
  assign ch_hit  = (pid_off[12:2] == 11'd0);
  assign ch      = pid_off[1:0];

  // AFC[0] (DATA[4]) says whether a payload is present, i.e. whether CC must advance
  always_comb begin
    last_cc_d = last_cc_q;
    seen_d    = seen_q;
    cc_mis    = 1'b0;
    afc_rsv   = 1'b0;
    cc_exp    = DATA[4] ? last_cc_q[ch] + 4'd1 : last_cc_q[ch];
    if (hdr3 && ch_hit) begin
      if (DATA[5:4] == 2'b00) begin
        afc_rsv = 1'b1;
      end else begin
        cc_mis        = seen_q[ch] && (DATA[3:0] != cc_exp);
        last_cc_d[ch] = DATA[3:0];
        seen_d[ch]    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_cc_q <= '0;
      seen_q    <= '0;
    end else begin
      last_cc_q <= last_cc_d;
      seen_q    <= seen_d;
    end
  end
`else
  assign cc_mis  = 1'b0;
  assign afc_rsv = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (D_VALID) begin
      unique case (state_q)
        HUNT: if (P_SYNC && is_sync) state_d = PKT;
        PKT: begin
          if (bc_q == '0) begin
            if (!(P_SYNC && is_sync)) state_d = HUNT;
          end else if (P_SYNC && !is_sync) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    bc_d       = bc_q;
    pid_hi_d   = pid_hi_q;
    pid_out_d  = pid_out_q;
    pid_stb_d  = 1'b0;
    sync_err_d = 1'b0;
    len_err_d  = 1'b0;
    cc_err_d   = cc_mis;
    pkt_err_d  = pkt_err_q;
    good_d     = good_q;
    locked_d   = locked_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (D_VALID) begin
      if (state_q == HUNT) begin
        if (P_SYNC && is_sync) begin
          bc_d      = BCW'(1);
          pkt_err_d = 1'b0;
        end else if (P_SYNC) begin
          sync_err_d = 1'b1;
        end
      end else if (bc_q == '0) begin
        if (P_SYNC && is_sync) begin
          bc_d      = BCW'(1);
          pkt_err_d = 1'b0;
        end else begin
          len_err_d  = !P_SYNC;
          sync_err_d = !is_sync;
        end
      end else if (P_SYNC) begin
        // early sync: the running packet is dropped
        len_err_d = 1'b1;
        if (is_sync) begin
          bc_d      = BCW'(1);
          pkt_err_d = 1'b0;
        end else begin
          sync_err_d = 1'b1;
          bc_d       = '0;
        end
      end else begin
        bc_d = bc_q + BCW'(1);
        if (bc_q == BCW'(1)) begin
          pid_hi_d = DATA[4:0];
          if (DATA[7]) pkt_err_d = 1'b1;
        end
        if (bc_q == BCW'(2)) begin
          pid_out_d = {pid_hi_q, DATA};
          pid_stb_d = 1'b1;
        end
        if (cc_mis || afc_rsv) pkt_err_d = 1'b1;
        if (bc_q == BCW'(PKT_LEN - 1)) begin
          bc_d = '0;
          if (!pkt_err_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            if (good_q != GW'(LOCK_CNT)) good_d = good_q + GW'(1);
          end else begin
            good_d = '0;
          end
        end
      end
    end
    if (good_d == GW'(LOCK_CNT)) locked_d = 1'b1;
    if (sync_err_d || len_err_d || cc_err_d) begin
      good_d   = '0;
      locked_d = 1'b0;
    end
    if (state_d == HUNT) locked_d = 1'b0;
  end

  assign err_inc   = {1'b0, sync_err_d} + {1'b0, len_err_d} + {1'b0, cc_err_d};
  assign err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
  assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bc_q       <= '0;
      pid_hi_q   <= '0;
      pid_out_q  <= '0;
      pid_stb_q  <= 1'b0;
      sync_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      cc_err_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      bc_q       <= bc_d;
      pid_hi_q   <= pid_hi_d;
      pid_out_q  <= pid_out_d;
      pid_stb_q  <= pid_stb_d;
      sync_err_q <= sync_err_d;
      len_err_q  <= len_err_d;
      cc_err_q   <= cc_err_d;
      pkt_err_q  <= pkt_err_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign LOCKED   = locked_q;
  assign SYNC_ERR = sync_err_q;
  assign LEN_ERR  = len_err_q;
  assign CC_ERR   = cc_err_q;
  assign PID_OUT  = pid_out_q;
  assign PID_STB  = pid_stb_q;
  assign PKT_CNT  = pkt_cnt_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_ts_checker.sv
// Bench for ts_checker: directed scenarios plus randomized gaps and interleaved PIDs,
// every cycle compared against a packet-rule reference model.
module tb_ts_checker;

`ifdef TS_CHECKER_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA = 8'd0;
  logic        D_VALID = 1'b0;
  logic        P_SYNC = 1'b0;
  logic        LOCKED, SYNC_ERR, LEN_ERR, CC_ERR, PID_STB;
  logic [12:0] PID_OUT;
  logic [31:0] PKT_CNT;
  logic [15:0] ERR_CNT;

  ts_checker dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .D_VALID(D_VALID), .P_SYNC(P_SYNC),
    .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR), .LEN_ERR(LEN_ERR), .CC_ERR(CC_ERR),
    .PID_OUT(PID_OUT), .PID_STB(PID_STB), .PKT_CNT(PKT_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int n_stb = 0, n_ccp = 0, n_lenp = 0, n_syncp = 0;
  int gap_max = 0;

  // reference model: expected registered outputs after the latest edge
  bit          m_hunt;
  int          m_pos, m_run;
  bit          m_bad;
  logic [4:0]  m_pid_hi;
  int          m_last[4];
  bit          m_seen[4];
  bit          e_locked, e_sync, e_len, e_cc, e_stb;
  logic [12:0] e_pid;
  logic [31:0] e_pkt;
  int          e_err;

  int gen_cc[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hunt = 1'b1; m_pos = 0; m_run = 0; m_bad = 1'b0; m_pid_hi = '0;
    for (int i = 0; i < 4; i++) begin m_last[i] = 0; m_seen[i] = 1'b0; end
    e_locked = 0; e_sync = 0; e_len = 0; e_cc = 0; e_stb = 0;
    e_pid = '0; e_pkt = '0; e_err = 0;
  endtask

  task automatic model(input logic v, input logic [7:0] d, input logic s);
    int n, ch, want;
    e_sync = 0; e_len = 0; e_cc = 0; e_stb = 0;
    if (v) begin
      if (m_hunt) begin
        if (s && d == 8'h47) begin m_hunt = 0; m_pos = 1; m_bad = 0; end
        else if (s) e_sync = 1;
      end else if (m_pos == 0) begin
        if (s && d == 8'h47) begin m_pos = 1; m_bad = 0; end
        else begin e_len = !s; e_sync = (d != 8'h47); m_hunt = 1; end
      end else if (s) begin
        e_len = 1;
        if (d == 8'h47) begin m_pos = 1; m_bad = 0; end
        else begin e_sync = 1; m_hunt = 1; m_pos = 0; end
      end else begin
        if (m_pos == 1) begin m_pid_hi = d[4:0]; if (d[7]) m_bad = 1; end
        if (m_pos == 2) begin e_pid = {m_pid_hi, d}; e_stb = 1; end
        if (m_pos == 3 && CC_EN) begin
          ch = int'(e_pid) - 'h1000;
          if (ch >= 0 && ch < 4) begin
            if (d[5:4] == 2'b00) m_bad = 1;
            else begin
              want = d[4] ? (m_last[ch] + 1) % 16 : m_last[ch];
              if (m_seen[ch] && int'(d[3:0]) != want) begin e_cc = 1; m_bad = 1; end
              m_last[ch] = int'(d[3:0]);
              m_seen[ch] = 1;
            end
          end
        end
        if (m_pos == 187) begin
          if (!m_bad) begin e_pkt = e_pkt + 1; m_run++; if (m_run >= 3) e_locked = 1; end
          else m_run = 0;
          m_pos = 0;
        end else m_pos++;
      end
    end
    n = int'(e_sync) + int'(e_len) + int'(e_cc);
    if (n > 0) begin m_run = 0; e_locked = 0; end
    if (m_hunt) e_locked = 0;
    e_err = (e_err + n > 65535) ? 65535 : e_err + n;
  endtask

  task automatic check_all();
    chk("locked",   LOCKED,   e_locked);
    chk("sync_err", SYNC_ERR, e_sync);
    chk("len_err",  LEN_ERR,  e_len);
    chk("cc_err",   CC_ERR,   e_cc);
    chk("pid_stb",  PID_STB,  e_stb);
    chk("pid_out",  PID_OUT,  e_pid);
    chk("pkt_cnt",  PKT_CNT,  e_pkt);
    chk("err_cnt",  ERR_CNT,  e_err);
    if (PID_STB)  n_stb++;
    if (CC_ERR)   n_ccp++;
    if (LEN_ERR)  n_lenp++;
    if (SYNC_ERR) n_syncp++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic s);
    D_VALID = v; DATA = d; P_SYNC = s;
    @(posedge CLK);
    model(v, d, s);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b0; D_VALID = 0; DATA = 0; P_SYNC = 0;
    #2;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    check_all();
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, gap_max);
    repeat (g) step(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic send_pkt(input logic [12:0] pid, input logic [1:0] afc, input logic [3:0] cc,
                          input bit tei, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      gap();
      case (i)
        0:       b = 8'h47;
        1:       b = {tei, 2'b00, pid[12:8]};
        2:       b = pid[7:0];
        3:       b = {2'b00, afc, cc};
        default: b = 8'($urandom);
      endcase
      step(1'b1, b, i == 0);
    end
  endtask

  initial begin
    int err0, len0, pkt0, sent;
    logic [12:0] pid;
    logic [1:0]  afc;
    logic [3:0]  cc;
    int ch;

    #3;
    do_reset();
    chk("rst_locked", LOCKED, 1'b0);
    chk("rst_pkt",    PKT_CNT, 32'd0);

    // five clean packets on channel 0, lock after the third
    for (int k = 0; k < 5; k++) begin
      send_pkt(13'h1000, 2'b01, 4'(k), 1'b0, 188);
      if (k == 1) chk("unlocked_after_2", LOCKED, 1'b0);
      if (k == 2) chk("locked_after_3", LOCKED, 1'b1);
    end
    chk("five_pkt_cnt", PKT_CNT, 32'd5);
    chk("five_err_cnt", ERR_CNT, 16'd0);
    chk("five_stb",     n_stb, 5);
    chk("five_pid",     PID_OUT, 13'h1000);

    // continuity jump 4 -> 6
    send_pkt(13'h1000, 2'b01, 4'd6, 1'b0, 188);
    chk("cc_jump_pulses", n_ccp, CC_EN ? 1 : 0);
    chk("cc_jump_pkt",    PKT_CNT, CC_EN ? 32'd5 : 32'd6);
    chk("cc_jump_err",    ERR_CNT, CC_EN ? 16'd1 : 16'd0);
    chk("cc_jump_lock",   LOCKED, CC_EN ? 1'b0 : 1'b1);
    send_pkt(13'h1000, 2'b01, 4'd7, 1'b0, 188);
    chk("cc_next_pkt",    PKT_CNT, CC_EN ? 32'd6 : 32'd7);
    for (int k = 8; k <= 10; k++) send_pkt(13'h1000, 2'b01, 4'(k), 1'b0, 188);
    chk("relock_cc", LOCKED, 1'b1);

    // short packet: sync at BC=100
    err0 = int'(ERR_CNT); len0 = n_lenp;
    send_pkt(13'h1000, 2'b01, 4'd11, 1'b0, 100);
    send_pkt(13'h1000, 2'b01, 4'd12, 1'b0, 188);
    chk("short_len_pulse", n_lenp - len0, 1);
    chk("short_err_cnt",   int'(ERR_CNT) - err0, 1);
    chk("short_unlocked",  LOCKED, 1'b0);
    send_pkt(13'h1000, 2'b01, 4'd13, 1'b0, 188);
    send_pkt(13'h1000, 2'b01, 4'd14, 1'b0, 188);
    chk("short_relock", LOCKED, 1'b1);

    // bad sync byte at BC=0
    err0 = int'(ERR_CNT); pkt0 = int'(PKT_CNT);
    step(1'b1, 8'h46, 1'b1);
    chk("badsync_pulse", SYNC_ERR, 1'b1);
    chk("badsync_nolen", LEN_ERR, 1'b0);
    chk("badsync_lock",  LOCKED, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 1'b0);
    send_pkt(13'h1000, 2'b01, 4'd15, 1'b0, 188);
    chk("badsync_err_cnt", int'(ERR_CNT) - err0, 1);
    chk("badsync_resume",  int'(PKT_CNT) - pkt0, 1);

    // interleaved channels with random gaps, one AFC=10 repeat
    gen_cc[0] = 15;
    for (int i = 1; i < 4; i++) gen_cc[i] = $urandom_range(0, 15);
    gap_max = 5;
    err0 = int'(ERR_CNT); pkt0 = int'(PKT_CNT); sent = 0;
    for (int k = 0; k < 16; k++) begin
      ch  = (k < 4) ? k : $urandom_range(0, 3);
      pid = 13'h1000 + 13'(ch);
      if (k == 9) afc = 2'b10;
      else begin afc = 2'b01; gen_cc[ch] = (gen_cc[ch] + 1) % 16; end
      cc = 4'(gen_cc[ch]);
      send_pkt(pid, afc, cc, 1'b0, 188);
      sent++;
    end
    chk("rand_err_cnt", int'(ERR_CNT) - err0, 0);
    chk("rand_pkt_cnt", int'(PKT_CNT) - pkt0, sent);

    // reset mid-packet, then a clean stream with fresh CC state
    gap_max = 0;
    send_pkt(13'h1000, 2'b01, 4'(gen_cc[0] + 1), 1'b0, 50);
    do_reset();
    chk("midrst_pkt", PKT_CNT, 32'd0);
    chk("midrst_err", ERR_CNT, 16'd0);
    gap_max = 2;
    send_pkt(13'h1001, 2'b01, 4'd9, 1'b0, 188);
    send_pkt(13'h1000, 2'b01, 4'd3, 1'b0, 188);
    send_pkt(13'h1000, 2'b01, 4'd4, 1'b0, 188);
    chk("post_rst_err", ERR_CNT, 16'd0);
    chk("post_rst_pkt", PKT_CNT, 32'd3);
    chk("post_rst_lock", LOCKED, 1'b1);

    // TEI and reserved AFC packets are not counted good and raise no pulse
    send_pkt(13'h1000, 2'b01, 4'd5, 1'b1, 188);
    chk("tei_pkt", PKT_CNT, 32'd3);
    send_pkt(13'h1000, 2'b00, 4'd0, 1'b0, 188);
    chk("afc00_pkt", PKT_CNT, CC_EN ? 32'd3 : 32'd4);
    send_pkt(13'h1000, 2'b01, 4'd6, 1'b0, 188);
    chk("after_afc00_err", ERR_CNT, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_checker.md
# ts_checker

Transport-stream integrity checker on the output of the 4-channel TS muxer. It consumes the muxed byte stream (DATA_OUT / D_VALID_OUT / P_SYNC_OUT), clocked by the muxer's output byte clock. It checks sync bytes, 188-byte packet length and per-PID continuity counters for the four generator PIDs, and reports lock state, error pulses and packet/error counters to the board debug logic.

## Interface
- PKT_LEN, 188: bytes per TS packet.
- PID_BASE, 13'h1000: first checked PID; channels n = 0..3 map to PID_BASE+n.
- LOCK_CNT, 3: consecutive good packets required to assert LOCKED.

- CLK  in  1  byte clock; the muxer's DCLK_OUT; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- DATA  in  8  stream byte, qualified by D_VALID.
- D_VALID  in  1  byte valid; cycles with D_VALID=0 are ignored entirely.
- P_SYNC  in  1  packet start flag, marks byte 0 (meaningful only with D_VALID=1).
- LOCKED  out  1  stream locked.
- SYNC_ERR  out  1  one-cycle pulse: bad sync byte.
- LEN_ERR  out  1  one-cycle pulse: short or long packet.
- CC_ERR  out  1  one-cycle pulse: continuity counter discontinuity.
- PID_OUT  out  13  PID of the most recent packet header.
- PID_STB  out  1  one-cycle pulse when PID_OUT updates.
- PKT_CNT  out  32  good-packet count, wraps at 2^32.
- ERR_CNT  out  16  total error events, saturates at 16'hFFFF.

## Operation
- Accepted byte: D_VALID=1 on a CLK edge. A byte counter BC (0..PKT_LEN-1) advances only on accepted bytes.
- States: HUNT, PKT.
- HUNT:
  - An accepted byte with P_SYNC=1 and DATA=8'h47 sets BC=1 and enters PKT.
  - P_SYNC=1 with DATA≠8'h47 pulses SYNC_ERR and stays in HUNT.
  - All other bytes are discarded silently.
- PKT header decode:
  - BC=1: PID[12:8]=DATA[4:0]; TEI=DATA[7].
  - BC=2: PID[7:0]=DATA; PID_OUT updates and PID_STB pulses.
  - BC=3: AFC=DATA[5:4], CC=DATA[3:0].
- Packet end: at BC=PKT_LEN-1 the packet completes.
  - If no error occurred in the packet: PKT_CNT+1 and the good-run counter +1.
  - Then BC=0 and the next byte is expected to be a sync byte.
- Short packet: P_SYNC=1 while BC≠0.
  - Pulse LEN_ERR and discard the packet.
  - If DATA=8'h47, restart at BC=1 (stay in PKT); otherwise pulse SYNC_ERR too and go to HUNT.
- Long packet / sync loss: byte at BC=0 with P_SYNC=0 or DATA≠8'h47.
  - With P_SYNC=0: pulse LEN_ERR.
  - With DATA≠8'h47: pulse SYNC_ERR.
  - Both apply if both conditions hold. Go to HUNT.
- TEI=1 counts as a packet error (the packet is not counted good) but produces no pulse.
- Continuity check (only when PID is in PID_BASE..PID_BASE+3):
  - Per-channel state: last_cc[3:0] plus a seen flag.
  - First packet on a channel: load last_cc, set seen, no check.
  - AFC[0]=1 (payload present): expect CC = last_cc+1 mod 16.
  - AFC[0]=0 (no payload): expect CC = last_cc.
  - Mismatch: pulse CC_ERR, mark the packet bad, and load last_cc=CC anyway.
  - AFC=2'b00: reserved; treated as a packet error and the CC state is not updated.
- LOCKED:
  - Set when the good-run counter reaches LOCK_CNT.
  - Any SYNC_ERR, LEN_ERR or CC_ERR clears LOCKED and the good-run counter.
  - Entering HUNT clears LOCKED.
- ERR_CNT adds the number of pulses asserted that cycle (0..3), saturating at 16'hFFFF.

## Timing
- All outputs are registered. Reset values: LOCKED=0, all pulses 0, PID_OUT=0, PKT_CNT=0, ERR_CNT=0. Internally: state=HUNT, BC=0, all seen flags 0.
- SYNC_ERR / LEN_ERR: one cycle after the offending accepted byte.
- PID_STB: one cycle after the BC=2 byte. CC_ERR: one cycle after the BC=3 byte.
- PKT_CNT and LOCKED: update one cycle after the last byte (BC=PKT_LEN-1).
- ERR_CNT: updates in the same cycle its pulses are visible.
- Back-to-back packets with no idle byte are supported. D_VALID gaps of any length anywhere in a packet do not affect results.
- Reset asserted mid-packet aborts the packet immediately; no pulse is emitted on release.

## Configuration
- TS_CHECKER_CC_EN:
  - Defined: the continuity check and per-channel CC state are built in, as above.
  - Undefined: no CC state exists, CC_ERR is tied 0, and AFC/CC are not checked (AFC=2'b00 is not an error). Sync, length, TEI, lock and counter behaviour are unchanged.

## Test plan
- Reset, then 5 clean 188-byte packets, PID 13'h1000, CC 0..4, AFC=01 -> LOCKED=1 one cycle after the end of packet 3; PKT_CNT=5; ERR_CNT=0; 5 PID_STB pulses with PID_OUT=13'h1000.
- Locked stream; packet 6 has CC=6 (expected 5) -> one CC_ERR pulse, LOCKED=0, PKT_CNT stays 5, ERR_CNT=1. Packet 7 with CC=7 is good.
- Locked stream; P_SYNC arrives with 8'h47 at BC=100 -> one LEN_ERR pulse, LOCKED=0, and a new packet restarts; 3 more clean packets relock.
- Byte at BC=0 with P_SYNC=1, DATA=8'h46 -> one SYNC_ERR pulse, HUNT entered, LOCKED=0; the next valid 8'h47 with P_SYNC resumes checking.
- Interleaved PIDs 13'h1000..13'h1003 with independent CCs, random D_VALID gaps of 0..5 cycles, and one AFC=10 packet repeating its CC -> no errors; PKT_CNT equals the packets sent.
- Reset pulsed at BC=50, then a clean stream -> no error pulses; ERR_CNT=0; seen flags are cleared, so the first CC on each channel is accepted.
